// File: rtl/fifo_packet.sv
// fifo_packet: stream FIFO with keep/last/tid sideband, occupancy flags and a stored-packet count.
// Define FIFO_PACKET_MODE_EN for store-and-forward operation with oversize-packet drop.
//
//  state  | meaning (FIFO_PACKET_MODE_EN only)
//  ACCEPT | beats are stored; an accepted tlast commits the packet to the read side
//  DROP   | oversize packet abandoned; beats are swallowed up to and including tlast
module fifo_packet #(
   parameter int WIDTH_IN_BYTES = 4,
   parameter int DEPTH_EXP      = 10,
   parameter int TID_WIDTH      = 8,
   parameter int AFULL_LEVEL    = 2**DEPTH_EXP - 4,
   parameter int AEMPTY_LEVEL   = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_tvalid,
   output logic                        in_tready,
   input  logic [8*WIDTH_IN_BYTES-1:0] in_tdata,
   input  logic [WIDTH_IN_BYTES-1:0]   in_tkeep,
   input  logic                        in_tlast,
   input  logic [TID_WIDTH-1:0]        in_tid,
   output logic                        out_tvalid,
   input  logic                        out_tready,
   output logic [8*WIDTH_IN_BYTES-1:0] out_tdata,
   output logic [WIDTH_IN_BYTES-1:0]   out_tkeep,
   output logic                        out_tlast,
   output logic [TID_WIDTH-1:0]        out_tid,
   output logic [DEPTH_EXP:0]          num_used,
   output logic [DEPTH_EXP:0]          num_free,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic                        drop_pulse,
   output logic [DEPTH_EXP:0]          pkt_count
);

   localparam int DW    = 8 * WIDTH_IN_BYTES;
   localparam int BW    = DW + WIDTH_IN_BYTES + TID_WIDTH + 1;
   localparam int DEPTH = 2 ** DEPTH_EXP;
   localparam logic [DEPTH_EXP:0] C_DEPTH  = (DEPTH_EXP+1)'(DEPTH);
   localparam logic [DEPTH_EXP:0] C_AFULL  = (DEPTH_EXP+1)'(AFULL_LEVEL);
   localparam logic [DEPTH_EXP:0] C_AEMPTY = (DEPTH_EXP+1)'(AEMPTY_LEVEL);
   localparam logic [DEPTH_EXP:0] C_ONE    = (DEPTH_EXP+1)'(1);

   logic [BW-1:0]      r_mem [DEPTH];
   logic [DEPTH_EXP:0] r_wr_ptr;
   logic [DEPTH_EXP:0] r_rd_ptr;
   logic [DEPTH_EXP:0] r_used;
   logic [DEPTH_EXP:0] r_pkt;
   logic               r_afull;
   logic               r_aempty;
   logic               r_out_valid;
   logic [BW-1:0]      r_out_beat;

   logic [BW-1:0]      w_in_beat;
   logic [BW-1:0]      w_head;
   logic [DEPTH_EXP:0] w_avail;
   logic [DEPTH_EXP:0] w_release;
   logic [DEPTH_EXP:0] w_wr_nxt;
   logic [DEPTH_EXP:0] w_used_nxt;
   logic [DEPTH_EXP:0] w_pkt_nxt;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_store;
   logic               w_deliver;
   logic               w_load;

   assign w_in_beat = {in_tlast, in_tid, in_tkeep, in_tdata};
   assign w_head    = r_mem[r_rd_ptr[DEPTH_EXP-1:0]];
   assign w_accept  = in_tvalid && w_in_ready;
   assign w_deliver = r_out_valid && out_tready;
   // output register refills on the same edge it empties, keeping one beat per clock
   assign w_load    = (w_avail != '0) && (!r_out_valid || out_tready);

`ifdef FIFO_PACKET_MODE_EN
   typedef enum logic {ST_ACCEPT = 1'b0, ST_DROP = 1'b1} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [DEPTH_EXP:0] r_cm_ptr;
   logic               r_drop_pulse;
   logic               w_enter_drop;

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_ACCEPT;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACCEPT: if (in_tvalid && !in_tlast && (r_used == C_DEPTH)) w_state_nxt = ST_DROP;
         ST_DROP:   if (in_tvalid && in_tlast) w_state_nxt = ST_ACCEPT;
         default:   w_state_nxt = ST_ACCEPT;
      endcase
   end

   always_comb begin
      w_in_ready   = (r_state == ST_DROP) || (r_used < C_DEPTH);
      w_store      = w_accept && (r_state == ST_ACCEPT);
      w_enter_drop = (r_state == ST_ACCEPT) && (w_state_nxt == ST_DROP);
      w_release    = w_enter_drop ? (r_wr_ptr - r_cm_ptr) : '0;
   end

   // read side only sees beats behind the commit pointer
   assign w_avail  = r_cm_ptr - r_rd_ptr;
   assign w_wr_nxt = w_enter_drop ? r_cm_ptr : (w_store ? r_wr_ptr + C_ONE : r_wr_ptr);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cm_ptr     <= '0;
         r_drop_pulse <= 1'b0;
      end else begin
         r_drop_pulse <= w_enter_drop;
         if (w_store && in_tlast) r_cm_ptr <= r_wr_ptr + C_ONE;
      end
   end

   assign drop_pulse = r_drop_pulse;
`else
   assign w_in_ready = r_used < C_DEPTH;
   assign w_store    = w_accept;
   assign w_release  = '0;
   assign w_avail    = r_wr_ptr - r_rd_ptr;
   assign w_wr_nxt   = w_store ? r_wr_ptr + C_ONE : r_wr_ptr;
   assign drop_pulse = 1'b0;
`endif

   assign w_used_nxt = r_used + (w_store ? C_ONE : '0) - (w_deliver ? C_ONE : '0) - w_release;
   assign w_pkt_nxt  = r_pkt + ((w_store && in_tlast) ? C_ONE : '0)
                             - ((w_deliver && r_out_beat[BW-1]) ? C_ONE : '0);

   always_ff @(posedge clk) begin
      if (w_store) r_mem[r_wr_ptr[DEPTH_EXP-1:0]] <= w_in_beat;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_used      <= '0;
         r_pkt       <= '0;
         r_out_valid <= 1'b0;
         r_afull     <= 1'b0;
         r_aempty    <= 1'b1;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_used   <= w_used_nxt;
         r_pkt    <= w_pkt_nxt;
         r_afull  <= (w_used_nxt >= C_AFULL);
         r_aempty <= (w_used_nxt <= C_AEMPTY);
         if (w_load) begin
            r_rd_ptr    <= r_rd_ptr + C_ONE;
            r_out_valid <= 1'b1;
         end else if (w_deliver) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // payload carries no reset; it is only meaningful while out_tvalid is high
   always_ff @(posedge clk) begin
      if (w_load) r_out_beat <= w_head;
   end

   assign in_tready    = w_in_ready;
   assign out_tvalid   = r_out_valid;
   assign {out_tlast, out_tid, out_tkeep, out_tdata} = r_out_beat;
   assign num_used     = r_used;
   assign num_free     = C_DEPTH - r_used;
   assign almost_full  = r_afull;
   assign almost_empty = r_aempty;
   assign pkt_count    = r_pkt;

endmodule

// File: doc/fifo_packet.md
FIFO_PACKET -- requirements
Module: fifo_packet

Interface
REQ-001 SHALL have parameter WIDTH_IN_BYTES, default 4, data width in bytes.
REQ-002 SHALL have parameter DEPTH_EXP, default 10, storage depth 2**DEPTH_EXP beats.
REQ-003 SHALL have parameter TID_WIDTH, default 8, width of tid sideband.
REQ-004 SHALL have parameter AFULL_LEVEL, default 2**DEPTH_EXP-4, almost_full threshold in beats.
REQ-005 SHALL have parameter AEMPTY_LEVEL, default 4, almost_empty threshold in beats.
REQ-006 SHALL have ports: clk in 1 (sole clock, rising edge); reset in 1 (synchronous, active-high).
REQ-007 SHALL have ports: in_tvalid in 1; in_tready out 1; in_tdata in 8*WIDTH_IN_BYTES; in_tkeep in WIDTH_IN_BYTES; in_tlast in 1; in_tid in TID_WIDTH.
REQ-008 SHALL have ports: out_tvalid, out_tready, out_tdata, out_tkeep, out_tlast, out_tid (mirror of input widths), all out_* registered.
REQ-009 SHALL have ports: num_used out DEPTH_EXP+1; num_free out DEPTH_EXP+1; almost_full out 1; almost_empty out 1; drop_pulse out 1; pkt_count out DEPTH_EXP+1.

Function
REQ-010 SHALL transfer a beat on any edge with tvalid&&tready; out_* SHALL hold stable while out_tvalid&&!out_tready.
REQ-011 SHALL count in num_used every accepted, undelivered beat, including the output register; num_free = 2**DEPTH_EXP - num_used.
REQ-012 SHALL drive in_tready = (num_used < 2**DEPTH_EXP); no beat is ever overwritten.
REQ-013 SHALL present a beat accepted at edge k into an empty FIFO on out_* with out_tvalid=1 after edge k+1 (1-cycle fall-through latency).
REQ-014 SHALL refill the output register on the same edge it is emptied (out_tready=1) when readable data exists, sustaining 1 beat/clock.
REQ-015 SHALL, on simultaneous accept and deliver, leave num_used unchanged.
REQ-016 SHALL wrap read/write pointers modulo 2**DEPTH_EXP with no gap or bubble at the wrap point.
REQ-017 SHALL drive almost_full = (num_used >= AFULL_LEVEL) and almost_empty = (num_used <= AEMPTY_LEVEL), registered, same cycle as num_used.
REQ-018 SHALL maintain pkt_count = number of stored beats with tlast=1 (incl. output register), +1 on accepted tlast, -1 on delivered tlast.

Reset
REQ-019 SHALL, with reset high at an edge, clear pointers, num_used, pkt_count, out_tvalid, drop_pulse to 0, set almost_empty=1, almost_full=0; out_tdata/tkeep/tlast/tid undefined.
REQ-020 SHALL discard all stored and partial packets on reset mid-operation; in_tready=1 from the first cycle after reset deasserts.

Configuration
REQ-021 SHALL, with macro FIFO_PACKET_MODE_EN defined, operate store-and-forward: read side only advances up to a commit pointer, updated on accepted tlast.
REQ-022 SHALL, in packet mode, use states ACCEPT and DROP: ACCEPT -> DROP when a non-tlast beat arrives with storage full; DROP -> ACCEPT on accepted tlast.
REQ-023 SHALL, in packet mode on entering DROP, rewind write pointer to commit pointer, release uncommitted beats from num_used, pulse drop_pulse 1 cycle, hold in_tready=1 and discard beats until tlast inclusive.
REQ-024 SHALL, without FIFO_PACKET_MODE_EN, act cut-through: every accepted beat readable, state machine absent, drop_pulse tied 0.

Verification
REQ-025 Bench SHALL: reset, one beat 0xA5A5A5A5 tlast=1 -> out_tvalid=1 after 2nd edge, num_used=1, pkt_count=1, almost_empty=1.
REQ-026 Bench SHALL: DEPTH_EXP=4, 16 writes out_tready=0 -> in_tready=0, num_used=16, num_free=0, almost_full=1; 17th beat not accepted.
REQ-027 Bench SHALL: continuous in/out 40 beats DEPTH_EXP=4 -> in-order data 0..39, num_used constant after fill, no bubble at pointer wrap.
REQ-028 Bench SHALL: FIFO_PACKET_MODE_EN, 3-beat packet tlast on beat 3 -> out_tvalid stays 0 until edge after beat 3 accepted.
REQ-029 Bench SHALL: FIFO_PACKET_MODE_EN, DEPTH_EXP=4, 20-beat packet -> drop_pulse once, num_used=0, next 2-beat packet delivered intact.
REQ-030 Bench SHALL: assert reset with 5 beats stored and out_tvalid=1 -> next cycle out_tvalid=0, num_used=0, pkt_count=0, in_tready=1.
